// File: rtl/host_line_pkg.sv
// host_line_pkg
//   Shared constants, types and the unpacker state enum for host_line_packer.
//   DEF_LINE_W / DEF_WORD_W are the default widths of the cache line and the
//   miner word; WORDS_PER_LINE and IDX_W are derived from them.
package host_line_pkg;

    localparam int DEF_LINE_W     = 512;
    localparam int DEF_WORD_W     = 32;
    localparam int WORDS_PER_LINE = DEF_LINE_W / DEF_WORD_W;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);

    typedef logic [DEF_LINE_W-1:0] line_t;
    typedef logic [DEF_WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]      idx_t;

    // Unpacker: EMPTY = no line buffered, HOLD = a line is being handed out.
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/host_line_packer_if.sv
// host_line_packer_if
//   Bundles the miner-side word handshakes and the DMA line-side signals.
//   master : the packer (pops/pushes DMA lines, sources rd_word, sinks wr_word)
//   slave  : the environment (DMA FIFOs plus miner)
//   Signals: dma_rd_data/dma_empty/dma_rd_en, rd_word/rd_word_valid/rd_word_ready,
//            wr_word/wr_word_valid/wr_word_ready, flush/flush_ack,
//            dma_wr_data/dma_full/dma_wr_en.
interface host_line_packer_if #(
    parameter int LINE_W = host_line_pkg::DEF_LINE_W,
    parameter int WORD_W = host_line_pkg::DEF_WORD_W
);
    logic [LINE_W-1:0] dma_rd_data;
    logic              dma_empty;
    logic              dma_rd_en;
    logic [WORD_W-1:0] rd_word;
    logic              rd_word_valid;
    logic              rd_word_ready;
    logic [WORD_W-1:0] wr_word;
    logic              wr_word_valid;
    logic              wr_word_ready;
    logic              flush;
    logic              flush_ack;
    logic [LINE_W-1:0] dma_wr_data;
    logic              dma_full;
    logic              dma_wr_en;

    modport master (
        input  dma_rd_data, dma_empty, rd_word_ready, wr_word, wr_word_valid,
               flush, dma_full,
        output dma_rd_en, rd_word, rd_word_valid, wr_word_ready, flush_ack,
               dma_wr_data, dma_wr_en
    );

    modport slave (
        output dma_rd_data, dma_empty, rd_word_ready, wr_word, wr_word_valid,
               flush, dma_full,
        input  dma_rd_en, rd_word, rd_word_valid, wr_word_ready, flush_ack,
               dma_wr_data, dma_wr_en
    );
endinterface

// File: rtl/host_word_packer.sv
// host_word_packer
//   Write path: packs miner words into cache lines and pushes them to the DMA
//   write channel; a flush pads a partial line with PAD_WORD and pushes it.
//   Ports: clk, rst_n (async, active-low), wr_word/wr_word_valid/wr_word_ready,
//          flush/flush_ack, dma_wr_data/dma_full/dma_wr_en.
module host_word_packer
    import host_line_pkg::*;
#(
    parameter int                LINE_W   = DEF_LINE_W,
    parameter int                WORD_W   = DEF_WORD_W,
    parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              wr_word_valid,
    output logic              wr_word_ready,
    input  logic              flush,
    output logic              flush_ack,
    output logic [LINE_W-1:0] dma_wr_data,
    input  logic              dma_full,
    output logic              dma_wr_en
);
    localparam int N  = LINE_W / WORD_W;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [LINE_W-1:0] line_q, line_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic              pending_q, pending_d;
    logic              flush_mark_q, flush_mark_d;   // pending line was produced by a flush
    logic              flush_wait_q, flush_wait_d;   // flush parked behind a pending line
    logic              idle_ack_q, idle_ack_d;       // flush with nothing to emit

    logic              drain;
    logic              ready;
    logic              accept;
    logic              flush_req;
    logic [IW:0]       idx_after;                    // fill level including this cycle's word
    logic [N-1:0]      pad_mask;

    assign drain     = pending_q & ~dma_full;
    // Output gated during reset so the miner never sees ready while held.
    assign ready     = rst_n & (~pending_q | ~dma_full);
    assign accept    = wr_word_valid & ready;
    assign flush_req = flush | flush_wait_q;
    assign idx_after = {1'b0, wr_idx_q} + {{IW{1'b0}}, accept};

    // Slots at or beyond the fill level are padded on a flush.
    for (genvar gi = 0; gi < N; gi++) begin : g_pad
        assign pad_mask[gi] = ((IW+1)'(gi) >= idx_after);
    end

    always_comb begin
        line_d       = line_q;
        wr_idx_d     = wr_idx_q;
        pending_d    = pending_q & ~drain;
        flush_mark_d = flush_mark_q & ~drain;
        flush_wait_d = flush_wait_q;
        idle_ack_d   = 1'b0;

        if (accept) begin
            line_d[wr_idx_q*WORD_W +: WORD_W] = wr_word;
            if (wr_idx_q == LAST_IDX) begin
                pending_d = 1'b1;
                wr_idx_d  = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (flush_req) begin
            if (pending_q) begin
                // Re-evaluate once the outstanding line has left.
                flush_wait_d = 1'b1;
            end else begin
                flush_wait_d = 1'b0;
                if (idx_after == (IW+1)'(N)) begin
                    // Word N-1 just completed the line: ack rides on its push.
                    flush_mark_d = 1'b1;
                end else if (idx_after != '0) begin
                    for (int k = 0; k < N; k++) begin
                        if (pad_mask[k]) begin
                            line_d[k*WORD_W +: WORD_W] = PAD_WORD;
                        end
                    end
                    pending_d    = 1'b1;
                    flush_mark_d = 1'b1;
                    wr_idx_d     = '0;
                end else begin
                    idle_ack_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q       <= '0;
            wr_idx_q     <= '0;
            pending_q    <= 1'b0;
            flush_mark_q <= 1'b0;
            flush_wait_q <= 1'b0;
            idle_ack_q   <= 1'b0;
        end else begin
            line_q       <= line_d;
            wr_idx_q     <= wr_idx_d;
            pending_q    <= pending_d;
            flush_mark_q <= flush_mark_d;
            flush_wait_q <= flush_wait_d;
            idle_ack_q   <= idle_ack_d;
        end
    end

    assign wr_word_ready = ready;
    assign dma_wr_en     = drain;
    assign dma_wr_data   = line_q;
    assign flush_ack     = (drain & flush_mark_q) | idle_ack_q;

endmodule

// File: rtl/host_line_packer.sv
// host_line_packer
//   Width adapter between 32-bit miner words and 512-bit DMA cache lines.
//   Read side (inline): pops a line, hands it out word 0 first, streams
//   back-to-back lines without a bubble. Write side: host_word_packer.
//   Ports: clk, rst_n (async, active-low), bus (host_line_packer_if.master),
//          rd_line_cnt / wr_line_cnt (line counters).
//   Build option: define HOST_LINE_PACKER_STATS_EN to build the wrapping line
//   counters; otherwise both counter outputs are tied to zero.
module host_line_packer
    import host_line_pkg::*;
#(
    parameter int                LINE_W   = DEF_LINE_W,
    parameter int                WORD_W   = DEF_WORD_W,
    parameter int                CNT_W    = 16,
    parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    host_line_packer_if.master  bus,
    output logic [CNT_W-1:0]    rd_line_cnt,
    output logic [CNT_W-1:0]    wr_line_cnt
);
    localparam int N  = LINE_W / WORD_W;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // ---------------- unpacker ----------------
    rd_state_e         state_q, state_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic              rd_en;
    logic [WORD_W-1:0] rd_words [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rd_words
        assign rd_words[gi] = rd_line_q[gi*WORD_W +: WORD_W];
    end

    always_comb begin
        state_d   = state_q;
        rd_line_d = rd_line_q;
        rd_idx_d  = rd_idx_q;
        rd_en     = 1'b0;
        case (state_q)
            EMPTY: begin
                // rst_n gate keeps the pop quiet while reset is held.
                if (rst_n && !bus.dma_empty) begin
                    rd_en     = 1'b1;
                    rd_line_d = bus.dma_rd_data;
                    rd_idx_d  = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.rd_word_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        if (!bus.dma_empty) begin
                            // Reload on the last handshake: no bubble between lines.
                            rd_en     = 1'b1;
                            rd_line_d = bus.dma_rd_data;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            rd_line_q <= '0;
            rd_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_line_q <= rd_line_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    assign bus.dma_rd_en     = rd_en;
    assign bus.rd_word_valid = (state_q == HOLD);
    assign bus.rd_word       = (state_q == HOLD) ? rd_words[rd_idx_q] : '0;

    // ---------------- packer ----------------
    logic              wr_ready;
    logic              wr_en;
    logic              ack;
    logic [LINE_W-1:0] wr_data;

    host_word_packer #(
        .LINE_W   (LINE_W),
        .WORD_W   (WORD_W),
        .PAD_WORD (PAD_WORD)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_word       (bus.wr_word),
        .wr_word_valid (bus.wr_word_valid),
        .wr_word_ready (wr_ready),
        .flush         (bus.flush),
        .flush_ack     (ack),
        .dma_wr_data   (wr_data),
        .dma_full      (bus.dma_full),
        .dma_wr_en     (wr_en)
    );

    assign bus.wr_word_ready = wr_ready;
    assign bus.dma_wr_en     = wr_en;
    assign bus.dma_wr_data   = wr_data;
    assign bus.flush_ack     = ack;

    // ---------------- line counters ----------------
`ifdef HOST_LINE_PACKER_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + CNT_W'(rd_en);
        wr_cnt_d = wr_cnt_q + CNT_W'(wr_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_line_cnt = rd_cnt_q;
    assign wr_line_cnt = wr_cnt_q;
`else
    assign rd_line_cnt = '0;
    assign wr_line_cnt = '0;
`endif

endmodule

// File: tb/tb_host_line_packer.sv
// Directed bench for host_line_packer: reset, read streaming and backpressure,
// write packing under dma_full, flush variants, line counters and mid-line reset.
module tb_host_line_packer;
    import host_line_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rd_line_cnt;
    logic [15:0] wr_line_cnt;

    always #5 clk = ~clk;

    host_line_packer_if #(.LINE_W(512), .WORD_W(32)) bus ();

    host_line_packer #(
        .LINE_W   (512),
        .WORD_W   (32),
        .CNT_W    (16),
        .PAD_WORD (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rd_line_cnt (rd_line_cnt),
        .wr_line_cnt (wr_line_cnt)
    );

    line_t       rdq [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_pop = 0;
    int          n_push = 0;
    line_t       wd;
    logic [31:0] e;
    int          exp_idx;

    function automatic line_t mk_line(logic [31:0] base);
        line_t l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic fifo_drive();
        bus.dma_empty   = (rdq.size() == 0);
        bus.dma_rd_data = (rdq.size() != 0) ? rdq[0] : '0;
    endtask

    // Sample the DMA strobes just before the edge, then model the FIFOs.
    task automatic cycle();
        logic rd_s, wr_s;
        #1;
        rd_s = bus.dma_rd_en;
        wr_s = bus.dma_wr_en;
        @(posedge clk);
        #1;
        if (rd_s) begin
            n_pop++;
            if (rdq.size() != 0) void'(rdq.pop_front());
        end
        if (wr_s) n_push++;
        fifo_drive();
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.rd_word_ready = 1'b0;
        bus.wr_word       = '0;
        bus.wr_word_valid = 1'b0;
        bus.flush         = 1'b0;
        bus.dma_full      = 1'b0;
        rdq.push_back(mk_line(32'hA000_0000));
        rdq.push_back(mk_line(32'hB000_0000));
        fifo_drive();

        // ---- 1. reset with a line waiting ----
        cycle();
        cycle();
        #1;
        chk("rst_rd_en", bus.dma_rd_en, 0);
        chk("rst_rd_valid", bus.rd_word_valid, 0);
        chk("rst_wr_en", bus.dma_wr_en, 0);
        chk("rst_wr_ready", bus.wr_word_ready, 0);
        chk("rst_flush_ack", bus.flush_ack, 0);
        chk("rst_pops", n_pop, 0);

        // ---- 2. read stream, two lines back to back ----
        rst_n = 1'b1;
        bus.rd_word_ready = 1'b1;
        #1;
        chk("rel_rd_en", bus.dma_rd_en, 1);
        chk("rel_wr_ready", bus.wr_word_ready, 1);
        cycle();
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? 32'hA000_0000 + 32'(k) : 32'hB000_0000 + 32'(k - 16);
            chk("rd_valid", bus.rd_word_valid, 1);
            chk("rd_word", bus.rd_word, e);
            cycle();
        end
        chk("rd_empty_valid", bus.rd_word_valid, 0);
        chk("rd_pops", n_pop, 2);

        // ---- 3. read backpressure, next line already waiting ----
        bus.rd_word_ready = 1'b0;
        rdq.push_back(mk_line(32'hC000_0000));
        rdq.push_back(mk_line(32'hD000_0000));
        fifo_drive();
        #1;
        chk("bp_first_pop", bus.dma_rd_en, 1);
        cycle();
        exp_idx = 0;
        for (int i = 0; i < 32; i++) begin
            bus.rd_word_ready = (i % 2 == 1);
            #1;
            chk("bp_word", bus.rd_word, 32'hC000_0000 + 32'(exp_idx));
            chk("bp_pops", n_pop, 3);
            cycle();
            if (i % 2 == 1) exp_idx++;
        end
        chk("bp_next_pop", n_pop, 4);
        chk("bp_next_word", bus.rd_word, 32'hD000_0000);
        bus.rd_word_ready = 1'b1;
        repeat (16) cycle();
        chk("bp_drain_valid", bus.rd_word_valid, 0);
        chk("bp_drain_pops", n_pop, 4);
        bus.rd_word_ready = 1'b0;

        // ---- 4. write pack with dma_full held ----
        bus.dma_full = 1'b1;
        bus.wr_word_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.wr_word = 32'(k + 1);
            #1;
            chk("pk_ready", bus.wr_word_ready, 1);
            cycle();
        end
        bus.wr_word_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("pk_full_ready", bus.wr_word_ready, 0);
            chk("pk_full_wr_en", bus.dma_wr_en, 0);
            cycle();
        end
        bus.dma_full = 1'b0;
        #1;
        wd = bus.dma_wr_data;
        chk("pk_wr_en", bus.dma_wr_en, 1);
        chk("pk_word0", wd[31:0], 32'h1);
        chk("pk_word15", wd[511:480], 32'h10);
        chk("pk_drain_ready", bus.wr_word_ready, 1);
        chk("pk_no_ack", bus.flush_ack, 0);
        cycle();
        chk("pk_wr_en_off", bus.dma_wr_en, 0);
        chk("pk_pushes", n_push, 1);

        // ---- 5. flush after three words ----
        bus.wr_word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wr_word = 32'h21 + 32'(k);
            cycle();
        end
        bus.wr_word_valid = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("fl_ack_early", bus.flush_ack, 0);
        cycle();
        bus.flush = 1'b0;
        #1;
        wd = bus.dma_wr_data;
        chk("fl_wr_en", bus.dma_wr_en, 1);
        chk("fl_ack", bus.flush_ack, 1);
        chk("fl_word0", wd[31:0], 32'h21);
        chk("fl_word2", wd[95:64], 32'h23);
        chk("fl_pad3", wd[127:96], 32'hDEADBEEF);
        chk("fl_pad15", wd[511:480], 32'hDEADBEEF);
        cycle();
        chk("fl_wr_en_off", bus.dma_wr_en, 0);
        chk("fl_ack_off", bus.flush_ack, 0);

        // flush with nothing buffered: ack next cycle, no push
        bus.flush = 1'b1;
        #1;
        chk("fi_ack_same", bus.flush_ack, 0);
        cycle();
        bus.flush = 1'b0;
        #1;
        chk("fi_ack", bus.flush_ack, 1);
        chk("fi_wr_en", bus.dma_wr_en, 0);
        cycle();
        chk("fi_ack_off", bus.flush_ack, 0);
        chk("fi_pushes", n_push, 2);

        // flush together with word 15: full line, ack with its push
        bus.wr_word_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.wr_word = 32'h30 + 32'(k);
            bus.flush = (k == 15);
            cycle();
        end
        bus.wr_word_valid = 1'b0;
        bus.flush = 1'b0;
        #1;
        wd = bus.dma_wr_data;
        chk("ff_wr_en", bus.dma_wr_en, 1);
        chk("ff_ack", bus.flush_ack, 1);
        chk("ff_word14", wd[479:448], 32'h3E);
        chk("ff_word15", wd[511:480], 32'h3F);
        cycle();
        chk("ff_pushes", n_push, 3);
        chk("ff_ack_off", bus.flush_ack, 0);

        // ---- 6. line counters ----
`ifdef HOST_LINE_PACKER_STATS_EN
        chk("st_rd_cnt", rd_line_cnt, 4);
        chk("st_wr_cnt", wr_line_cnt, 3);
`else
        chk("st_rd_cnt_tied", rd_line_cnt, 0);
        chk("st_wr_cnt_tied", wr_line_cnt, 0);
`endif

        // reset in the middle of a read line and a partial write line
        rdq.push_back(mk_line(32'hE000_0000));
        fifo_drive();
        cycle();
        bus.wr_word_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.wr_word = 32'h50 + 32'(k);
            cycle();
        end
        bus.wr_word_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rd_valid", bus.rd_word_valid, 0);
        chk("mr_rd_cnt", rd_line_cnt, 0);
        chk("mr_wr_cnt", wr_line_cnt, 0);
        chk("mr_wr_ready", bus.wr_word_ready, 0);
        cycle();
        rst_n = 1'b1;
        bus.wr_word_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.wr_word = 32'h100 + 32'(k);
            cycle();
        end
        bus.wr_word_valid = 1'b0;
        #1;
        wd = bus.dma_wr_data;
        chk("mr_wr_en", bus.dma_wr_en, 1);
        chk("mr_word0", wd[31:0], 32'h100);
        chk("mr_word15", wd[511:480], 32'h10F);
        cycle();
        chk("mr_pushes", n_push, 4);
`ifdef HOST_LINE_PACKER_STATS_EN
        chk("mr_wr_cnt_after", wr_line_cnt, 1);
        chk("mr_rd_cnt_after", rd_line_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
